hsc_ddr2_frame_wr: RTL and testbench
====================================

// Module: hsc_ddr2_frame_wr
// PURPOSE
//  Upstream write-side stage of the DDR2 frame store. Takes a 16-bit pixel stream
//  (vsync/de/data) and packs pixel pairs into 32-bit words for the user write port
//  (wr_req/wr_data). Drives wr_load and the wr_minaddr/wr_maxaddr window per frame.
//  Ping-pongs between two frame banks; publishes the last complete bank on rd_bank.
// PARAMETERS
//  FRAME_WORDS  24'd153600  32-bit words per frame (640x480x16bpp); must be >=2
//  BANK0_BASE   24'h000000  first word address of bank 0
//  BANK1_BASE   24'h040000  first word address of bank 1
//  LOAD_CYCLES  4           wr_load pulse length in clk cycles, 1..15
//  VSYNC_POL    1'b1        active level of pix_vsync; frame starts on its active edge
// PORTS
//  clk              in   1   write clock; also drives wr_clk of the user write port
//  rst_n            in   1   async active-low reset
//  local_init_done  in   1   DDR2 init done, phy clock domain; 2-FF synchronised inside
//  pix_vsync        in   1   frame sync, synchronous to clk
//  pix_de           in   1   pixel valid qualifier
//  pix_data         in  16   pixel
//  wr_req           out  1   one-cycle word write strobe
//  wr_data          out 32   packed word: [31:16] = first pixel, [15:0] = second pixel
//  wr_load          out  1   write-port reset (address and FIFO)
//  wr_minaddr       out 24   current bank base
//  wr_maxaddr       out 24   current bank base + FRAME_WORDS
//  rd_bank          out  1   bank index of the last committed frame
//  frame_done       out  1   one-cycle pulse when a frame is committed
//  err_short        out  1   one-cycle pulse when a frame is aborted early by vsync
// BEHAVIOUR
//  Reset: FSM=WAIT_INIT; wr_req=0, wr_data=0, wr_load=0, frame_done=0, err_short=0,
//   rd_bank=0, write bank=0, wr_minaddr=BANK0_BASE, wr_maxaddr=BANK0_BASE+FRAME_WORDS.
//  vs_edge = sampled pix_vsync reaches VSYNC_POL while the previous sample did not
//   (1 flop edge detect; the flop resets to !VSYNC_POL).
//  FSM states:
//   WAIT_INIT: ignore pixels. Go to IDLE when the synchronised init_done = 1.
//   IDLE:      ignore pixels. On vs_edge go to LOAD.
//   LOAD:      wr_load=1 for exactly LOAD_CYCLES cycles, then go to RUN.
//              The half-word flag and word counter are cleared on entry.
//   RUN:       pack pixels (see below). On commit go to IDLE. On vs_edge: err_short
//              pulse, then go to LOAD with the same bank (no commit).
//  Any state: synchronised init_done = 0 -> WAIT_INIT. Drop the partial word.
//   Bank and rd_bank are unchanged. wr_load and wr_req are forced low.
//  Packing in RUN:
//   - First pixel with de is held as the high half.
//   - Second pixel with de: on the next cycle wr_req=1 with wr_data = {held, pix_data}.
//     Latency is 1 cycle. Back-to-back de gives wr_req every 2nd cycle.
//   - pix_de is ignored outside RUN.
//  Word counter: 24-bit, increments per wr_req.
//   On the wr_req cycle that brings it to FRAME_WORDS (commit):
//   - frame_done=1 and rd_bank <= current bank.
//   - Bank toggles. wr_minaddr/wr_maxaddr update on the following cycle to the new bank.
//   - FSM goes to IDLE. Extra pixels before the next vsync are discarded.
//  Simultaneous events: vs_edge has priority over pix_de in the same cycle, so that
//   pixel is dropped. A pending wr_req already scheduled still issues. A vs_edge in
//   LOAD is ignored.
//  Odd trailing pixel at vs_edge is dropped, never written.
//  Arithmetic: wr_maxaddr = base + FRAME_WORDS, 24-bit, wraps modulo 2^24.
// TESTING (bench uses FRAME_WORDS=4, LOAD_CYCLES=2, BANK1_BASE=24'h000100)
//  1 Hold init_done=0, drive vsync and de -> no wr_load, no wr_req.
//    Raise init_done -> FSM reaches IDLE 2-3 cycles later.
//  2 vsync edge, 8 pixels 16'h0001..16'h0008 with de continuous
//    -> wr_load high 2 cycles.
//    -> wr_data 32'h00010002, 00030004, 00050006, 00070008, each 1 cycle after the 2nd pixel.
//    -> frame_done with rd_bank=0; then wr_minaddr=24'h000100, wr_maxaddr=24'h000104.
//  3 Next frame, only 5 pixels, then vsync
//    -> 2 wr_req, err_short=1, wr_load again with wr_minaddr still 24'h000100, rd_bank stays 0.
//  4 Two full frames back-to-back -> rd_bank 1 then 0; wr_minaddr alternates 0x100 / 0x000.
//  5 Drop init_done mid-RUN after 3 pixels -> wr_req stops, FSM=WAIT_INIT.
//    Re-raise it plus vsync -> restarts on the same bank with a clean pair alignment.
//  6 Assert rst_n=0 mid-frame, asynchronously -> all outputs take reset values immediately.

Source files
------------

// File: rtl/hsc_ddr2_frame_wr.sv
// Write-side stage of the DDR2 frame store: packs 16-bit pixel pairs into 32-bit words,
// manages the per-frame write window and ping-pongs between two frame banks.
module hsc_ddr2_frame_wr #(
    parameter logic [23:0] FRAME_WORDS = 24'd153600,
    parameter logic [23:0] BANK0_BASE  = 24'h000000,
    parameter logic [23:0] BANK1_BASE  = 24'h040000,
    parameter int unsigned LOAD_CYCLES = 4,
    parameter logic        VSYNC_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        local_init_done,
    input  logic        pix_vsync,
    input  logic        pix_de,
    input  logic [15:0] pix_data,
    output logic        wr_req,
    output logic [31:0] wr_data,
    output logic        wr_load,
    output logic [23:0] wr_minaddr,
    output logic [23:0] wr_maxaddr,
    output logic        rd_bank,
    output logic        frame_done,
    output logic        err_short,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_WAIT_INIT = 2'd0,
        S_IDLE      = 2'd1,
        S_LOAD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);

    state_t      state;
    logic        init_meta;
    logic        init_sync;
    logic        vs_prev;
    logic        vs_edge;
    logic        half;
    logic        bank;
    logic [15:0] hold;
    logic [23:0] word_cnt;
    logic [23:0] word_cnt_nxt;
    logic [3:0]  load_cnt;

    assign vs_edge      = (pix_vsync == VSYNC_POL) && (vs_prev != VSYNC_POL);
    assign word_cnt_nxt = word_cnt + 24'd1;
    assign fsm_state    = state;

    // init_done comes from the phy clock domain; vs_prev resets inactive so a
    // vsync already active out of reset still counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_meta <= 1'b0;
            init_sync <= 1'b0;
            vs_prev   <= ~VSYNC_POL;
        end else begin
            init_meta <= local_init_done;
            init_sync <= init_meta;
            vs_prev   <= pix_vsync;
        end
    end

    // The window follows the bank one cycle after it toggles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_minaddr <= BANK0_BASE;
            wr_maxaddr <= BANK0_BASE + FRAME_WORDS;
        end else begin
            wr_minaddr <= bank ? BANK1_BASE : BANK0_BASE;
            wr_maxaddr <= (bank ? BANK1_BASE : BANK0_BASE) + FRAME_WORDS;
        end
    end

    // wr_req is a one-cycle strobe with no back-pressure: each high cycle delivers
    // exactly one wr_data word to the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_WAIT_INIT;
            wr_req     <= 1'b0;
            wr_data    <= 32'd0;
            wr_load    <= 1'b0;
            rd_bank    <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            bank       <= 1'b0;
            half       <= 1'b0;
            hold       <= 16'd0;
            word_cnt   <= 24'd0;
            load_cnt   <= 4'd0;
        end else begin
            wr_req     <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            if (!init_sync) begin
                state   <= S_WAIT_INIT;
                wr_load <= 1'b0;
                half    <= 1'b0;
            end else begin
                case (state)
                    S_WAIT_INIT: state <= S_IDLE;
                    S_IDLE: begin
                        if (vs_edge) begin
                            state    <= S_LOAD;
                            wr_load  <= 1'b1;
                            load_cnt <= LOAD_LAST;
                            half     <= 1'b0;
                            word_cnt <= 24'd0;
                        end
                    end
                    S_LOAD: begin
                        if (load_cnt == 4'd0) begin
                            wr_load <= 1'b0;
                            state   <= S_RUN;
                        end else begin
                            load_cnt <= load_cnt - 4'd1;
                        end
                    end
                    S_RUN: begin
                        if (vs_edge) begin
                            // Frame cut short: restart the same bank, drop any held pixel.
                            err_short <= 1'b1;
                            state     <= S_LOAD;
                            wr_load   <= 1'b1;
                            load_cnt  <= LOAD_LAST;
                            half      <= 1'b0;
                            word_cnt  <= 24'd0;
                        end else if (pix_de) begin
                            if (!half) begin
                                hold <= pix_data;
                                half <= 1'b1;
                            end else begin
                                wr_req   <= 1'b1;
                                wr_data  <= {hold, pix_data};
                                half     <= 1'b0;
                                word_cnt <= word_cnt_nxt;
                                if (word_cnt_nxt == FRAME_WORDS) begin
                                    frame_done <= 1'b1;
                                    rd_bank    <= bank;
                                    bank       <= ~bank;
                                    state      <= S_IDLE;
                                end
                            end
                        end
                    end
                    default: state <= S_WAIT_INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hsc_ddr2_frame_wr.sv
// Bench for hsc_ddr2_frame_wr: small frames, scoreboard of expected words and
// committed banks, plus directed init-drop and async-reset scenarios.
module tb_hsc_ddr2_frame_wr;

    localparam logic [23:0] FW  = 24'd4;
    localparam logic [23:0] B0  = 24'h000000;
    localparam logic [23:0] B1  = 24'h000100;
    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        local_init_done = 1'b0;
    logic        pix_vsync = 1'b0;
    logic        pix_de = 1'b0;
    logic [15:0] pix_data = 16'd0;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        wr_load;
    logic [23:0] wr_minaddr;
    logic [23:0] wr_maxaddr;
    logic        rd_bank;
    logic        frame_done;
    logic        err_short;
    logic [1:0]  fsm_state;

    hsc_ddr2_frame_wr #(
        .FRAME_WORDS(FW),
        .BANK0_BASE (B0),
        .BANK1_BASE (B1),
        .LOAD_CYCLES(2),
        .VSYNC_POL  (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .local_init_done(local_init_done),
        .pix_vsync      (pix_vsync),
        .pix_de         (pix_de),
        .pix_data       (pix_data),
        .wr_req         (wr_req),
        .wr_data        (wr_data),
        .wr_load        (wr_load),
        .wr_minaddr     (wr_minaddr),
        .wr_maxaddr     (wr_maxaddr),
        .rd_bank        (rd_bank),
        .frame_done     (frame_done),
        .err_short      (err_short),
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int load_cycles = 0;
    int err_cnt = 0;
    int done_cnt = 0;

    logic [31:0] exp_q[$];
    logic [0:0]  exp_bank_q[$];

    bit          live = 1'b0;
    bit          tb_half = 1'b0;
    bit          tb_bank = 1'b0;
    logic [15:0] tb_hold = 16'd0;
    int          tb_words = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        for (int i = 0; i < 20 && fsm_state != s; i++) tick();
        check(tag, {30'd0, fsm_state}, {30'd0, s});
    endtask

    // Drives one pixel with de held high; the model decides what the DUT must write.
    task automatic px(input logic [15:0] d);
        pix_de   = 1'b1;
        pix_data = d;
        if (live) begin
            if (!tb_half) begin
                tb_hold = d;
                tb_half = 1'b1;
            end else begin
                exp_q.push_back({tb_hold, d});
                tb_half = 1'b0;
                tb_words++;
                if (tb_words == int'(FW)) begin
                    exp_bank_q.push_back(tb_bank);
                    tb_bank = ~tb_bank;
                    live = 1'b0;
                end
            end
        end
        tick();
    endtask

    task automatic gap();
        pix_de = 1'b0;
        tick();
    endtask

    task automatic start_frame(input string tag);
        pix_de    = 1'b0;
        pix_vsync = 1'b1;
        tick();
        pix_vsync = 1'b0;
        tb_half   = 1'b0;
        tb_words  = 0;
        live      = 1'b1;
        wait_state(ST_RUN, tag);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_load) load_cycles++;
            if (err_short) err_cnt++;
            if (wr_req) begin
                if (exp_q.size() == 0) check("wr_req_unexpected", {31'd0, wr_req}, 32'd0);
                else check("wr_data", wr_data, exp_q.pop_front());
            end
            if (frame_done) begin
                done_cnt++;
                check("done_with_req", {31'd0, wr_req}, 32'd1);
                if (exp_bank_q.size() == 0) check("frame_done_unexpected", {31'd0, frame_done}, 32'd0);
                else check("rd_bank_commit", {31'd0, rd_bank}, {31'd0, exp_bank_q.pop_front()});
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_state", {30'd0, fsm_state}, {30'd0, ST_WAIT});
        check("rst_minaddr", {8'd0, wr_minaddr}, {8'd0, B0});
        check("rst_maxaddr", {8'd0, wr_maxaddr}, {8'd0, B0 + FW});
        check("rst_outputs", {27'd0, wr_req, wr_load, rd_bank, frame_done, err_short}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: no activity before init_done
        pix_vsync = 1'b1;
        tick();
        pix_vsync = 1'b0;
        for (int i = 0; i < 6; i++) px(16'($urandom_range(0, 65535)));
        gap();
        check("pre_init_load", load_cycles, 0);
        check("pre_init_state", {30'd0, fsm_state}, {30'd0, ST_WAIT});
        local_init_done = 1'b1;
        repeat (3) tick();
        check("init_idle", {30'd0, fsm_state}, {30'd0, ST_IDLE});

        // 2: first full frame into bank 0
        start_frame("f1_run");
        check("f1_load_len", load_cycles, 2);
        for (int i = 1; i <= 8; i++) px(16'(i));
        gap();
        tick();
        check("f1_done", done_cnt, 1);
        check("f1_rd_bank", {31'd0, rd_bank}, 32'd0);
        check("f1_minaddr", {8'd0, wr_minaddr}, {8'd0, B1});
        check("f1_maxaddr", {8'd0, wr_maxaddr}, {8'd0, B1 + FW});

        // 3: short frame aborted by vsync
        start_frame("f2_run");
        for (int i = 0; i < 5; i++) px(16'h0020 + 16'(i));
        gap();
        start_frame("f2_restart");
        check("f2_err", err_cnt, 1);
        check("f2_load_len", load_cycles, 6);
        check("f2_minaddr", {8'd0, wr_minaddr}, {8'd0, B1});
        check("f2_rd_bank", {31'd0, rd_bank}, 32'd0);

        // 4: two full frames with random data and de gaps
        for (int i = 0; i < 8; i++) begin
            px(16'($urandom_range(0, 65535)));
            if ($urandom_range(0, 1) == 1) gap();
        end
        px(16'hdead);
        px(16'hbeef);
        gap();
        tick();
        check("f3_rd_bank", {31'd0, rd_bank}, 32'd1);
        check("f3_minaddr", {8'd0, wr_minaddr}, {8'd0, B0});
        start_frame("f4_run");
        for (int i = 0; i < 8; i++) px(16'($urandom_range(0, 65535)));
        gap();
        tick();
        check("f4_done", done_cnt, 3);
        check("f4_rd_bank", {31'd0, rd_bank}, 32'd0);
        check("f4_minaddr", {8'd0, wr_minaddr}, {8'd0, B1});

        // 5: init_done drops mid-frame, restart on the same bank
        start_frame("f5_run");
        px(16'h0a01);
        px(16'h0a02);
        px(16'h0a03);
        pix_de = 1'b0;
        local_init_done = 1'b0;
        live = 1'b0;
        tb_half = 1'b0;
        repeat (4) tick();
        check("drop_state", {30'd0, fsm_state}, {30'd0, ST_WAIT});
        check("drop_minaddr", {8'd0, wr_minaddr}, {8'd0, B1});
        check("drop_rd_bank", {31'd0, rd_bank}, 32'd0);
        local_init_done = 1'b1;
        wait_state(ST_IDLE, "reinit_idle");
        start_frame("f6_run");
        for (int i = 0; i < 8; i++) px(16'h0b00 + 16'(i));
        gap();
        tick();
        check("f6_done", done_cnt, 4);
        check("f6_rd_bank", {31'd0, rd_bank}, 32'd1);
        check("f6_minaddr", {8'd0, wr_minaddr}, {8'd0, B0});

        // 6: asynchronous reset mid-frame
        start_frame("f7_run");
        px(16'h0c01);
        px(16'h0c02);
        px(16'h0c03);
        pix_de = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", {30'd0, fsm_state}, {30'd0, ST_WAIT});
        check("arst_outputs", {27'd0, wr_req, wr_load, rd_bank, frame_done, err_short}, 32'd0);
        check("arst_wr_data", wr_data, 32'd0);
        check("arst_minaddr", {8'd0, wr_minaddr}, {8'd0, B0});
        check("arst_maxaddr", {8'd0, wr_maxaddr}, {8'd0, B0 + FW});
        check("exp_q_drained", exp_q.size(), 0);
        check("bank_q_drained", exp_bank_q.size(), 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
